// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 4-digit 7-segment driver from packed BCD
module seg7_scan_driver #(
  parameter int DIGIT_CYCLES   = 40,
  parameter int BLANK_CYCLES   = 2,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  sel,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);
  localparam int MAX_CYC = DIGIT_CYCLES > BLANK_CYCLES ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] LIT_LD = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] GRD_LD = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
  localparam bit HAS_GUARD = BLANK_CYCLES > 0;
  localparam bit SEL_LOW = SEL_ACTIVE_LOW != 0;
  localparam bit SEG_LOW = SEG_ACTIVE_LOW != 0;
  typedef enum logic [1:0] {IDLE, GUARD, LIT} state_t;
  state_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] d, d_n;
  logic [15:0] sh_val, sh_val_n;
  logic [3:0] sh_dp, sh_dp_n;
  logic sh_blz, sh_blz_n;
  logic start_frame, lz1, lz2, lz3, blanked, lit, dp_n, fd_n;
  logic [3:0] nib, sel_hot;
  logic [6:0] pat, seg_n;
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b0111111;
      4'h1: decode = 7'b0000110;
      4'h2: decode = 7'b1011011;
      4'h3: decode = 7'b1001111;
      4'h4: decode = 7'b1100110;
      4'h5: decode = 7'b1101101;
      4'h6: decode = 7'b1111101;
      4'h7: decode = 7'b0000111;
      4'h8: decode = 7'b1111111;
      4'h9: decode = 7'b1101111;
      4'hA: decode = 7'b1000000;
      default: decode = 7'b0000000;
    endcase
  endfunction
  // next state: guard/lit sequencing per digit, shadow capture on entry to digit 0
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    d_n = d;
    if (!en) begin
      st_n = IDLE;
      cnt_n = '0;
      d_n = '0;
    end else if (st == IDLE || (st == LIT && cnt == '0)) begin
      d_n = st == IDLE ? 2'd0 : d + 2'd1;
      st_n = HAS_GUARD ? GUARD : LIT;
      cnt_n = HAS_GUARD ? GRD_LD : LIT_LD;
    end else if (st == GUARD && cnt == '0) begin
      st_n = LIT;
      cnt_n = LIT_LD;
    end else begin
      cnt_n = cnt - 1'b1;
    end
    start_frame = en && (st == IDLE || (st == LIT && cnt == '0 && d == 2'd3));
    sh_val_n = start_frame ? value : sh_val;
    sh_dp_n = start_frame ? dp_mask : sh_dp;
    sh_blz_n = start_frame ? blank_lz : sh_blz;
  end
  // output decode for the state being entered, so registered outputs align with it
  always_comb begin
    nib = sh_val_n[d_n*4 +: 4];
    lz3 = sh_val_n[15:12] == 4'h0;
    lz2 = lz3 && sh_val_n[11:8] == 4'h0;
    lz1 = lz2 && sh_val_n[7:4] == 4'h0;
    blanked = sh_blz_n && (d_n == 2'd3 ? lz3 : d_n == 2'd2 ? lz2 : d_n == 2'd1 ? lz1 : 1'b0);
    pat = decode(nib);
    lit = st_n == LIT;
    sel_hot = lit && (!blanked || sh_dp_n[d_n]) ? 4'b0001 << d_n : 4'b0000;
    seg_n = lit && !blanked ? pat : 7'b0000000;
    dp_n = lit && sh_dp_n[d_n];
    fd_n = lit && d_n == 2'd3 && cnt_n == '0;
  end
  // state, shadow and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      cnt <= '0;
      d <= '0;
      sh_val <= '0;
      sh_dp <= '0;
      sh_blz <= 1'b0;
      seg <= SEG_LOW ? 7'h7F : 7'h00;
      dp <= SEG_LOW;
      sel <= SEL_LOW ? 4'hF : 4'h0;
      digit_idx <= '0;
      frame_done <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      d <= d_n;
      sh_val <= sh_val_n;
      sh_dp <= sh_dp_n;
      sh_blz <= sh_blz_n;
      seg <= SEG_LOW ? ~seg_n : seg_n;
      dp <= SEG_LOW ? ~dp_n : dp_n;
      sel <= SEL_LOW ? ~sel_hot : sel_hot;
      digit_idx <= d_n;
      frame_done <= fd_n;
    end
  end
endmodule
